// File: rtl/fan_ctrl_pkg.sv
// Shared types, widths and default thresholds for the fan speed controller.
// Also holds the temperature-to-target mapping used by the top level.
package fan_ctrl_pkg;

    localparam int unsigned PWM_W = 8;
    localparam int unsigned RPM_W = 16;

    typedef logic [PWM_W-1:0] duty_t;
    typedef logic [RPM_W-1:0] rpm_t;
    typedef logic [RPM_W:0]   rpm_ext_t;

    typedef enum logic [2:0] {
        StOff      = 3'd0,
        StKick     = 3'd1,
        StSettle   = 3'd2,
        StRegulate = 3'd3,
        StStall    = 3'd4,
        StFault    = 3'd5
    } fan_state_e;

    localparam int unsigned DEF_T_ON        = 30;
    localparam int unsigned DEF_T_HYST      = 3;
    localparam int unsigned DEF_RPM_MIN     = 600;
    localparam int unsigned DEF_RPM_PER_DEG = 100;
    localparam int unsigned DEF_RPM_MAX     = 3000;

    // Wide intermediate so a hot sensor reading saturates instead of wrapping.
    function automatic rpm_t temp_to_rpm(logic [7:0] temp, int unsigned t_on,
                                         int unsigned rpm_min, int unsigned rpm_per_deg,
                                         int unsigned rpm_max);
        logic [23:0] span;
        if (temp < 8'(t_on)) begin
            return '0;
        end
        span = 24'(rpm_min) + 24'(temp - 8'(t_on)) * 24'(rpm_per_deg);
        if (span > 24'(rpm_max)) begin
            return rpm_t'(rpm_max);
        end
        return rpm_t'(span);
    endfunction

endpackage

// File: rtl/fan_speed_ctrl_if.sv
// Signal bundle between the fan controller and its sensor/driver environment.
// The master side supplies sensor data and strobes; the slave side is the controller.
interface fan_speed_ctrl_if;
    import fan_ctrl_pkg::*;

    logic [7:0] temp_c;
    logic       temp_valid;
    rpm_t       rpm;
    logic       fg_signal;
    logic       fault_clr;
    logic       pwm_out;
    duty_t      duty;
    rpm_t       target_rpm;
    logic [2:0] state;
    logic       stall_alarm;

    modport master (
        output temp_c, temp_valid, rpm, fg_signal, fault_clr,
        input  pwm_out, duty, target_rpm, state, stall_alarm
    );

    modport slave (
        input  temp_c, temp_valid, rpm, fg_signal, fault_clr,
        output pwm_out, duty, target_rpm, state, stall_alarm
    );

endinterface

// File: rtl/fan_pwm_gen.sv
// 8-bit PWM generator with prescaler; duty is taken only at the period wrap so
// a mid-period duty change never produces a runt or stretched pulse.
module fan_pwm_gen
    import fan_ctrl_pkg::*;
#(
    parameter int unsigned PWM_DIV = 8
) (
    input  logic  sys_clk,
    input  logic  sys_rst_n,
    input  duty_t duty,
    output logic  pwm_out
);

    localparam int unsigned DivW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

    logic [DivW-1:0] div_q, div_d;
    duty_t           cnt_q, cnt_d;
    duty_t           active_q, active_d;
    logic            pwm_d;
    logic            step;

    always_comb begin
        step     = (div_q == DivW'(PWM_DIV - 1));
        div_d    = step ? '0 : div_q + DivW'(1);
        cnt_d    = step ? cnt_q + duty_t'(1) : cnt_q;
        active_d = (step && cnt_q == '1) ? duty : active_q;
        // Full scale is forced high; otherwise cnt==255 would leave one low slot.
        pwm_d    = (active_q == '1) || (cnt_q < active_q);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            div_q    <= '0;
            cnt_q    <= '0;
            active_q <= '0;
            pwm_out  <= 1'b0;
        end else begin
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            pwm_out  <= pwm_d;
        end
    end

endmodule

// File: rtl/fan_speed_ctrl.sv
// Closed-loop fan controller: temperature sets a target RPM, the FSM kick-starts,
// regulates duty toward the target, detects stall, retries and latches a fault.
module fan_speed_ctrl
    import fan_ctrl_pkg::*;
#(
    parameter int unsigned TICK_CYC    = 50000,
    parameter int unsigned UPDATE_MS   = 100,
    parameter int unsigned KICK_MS     = 500,
    parameter int unsigned SETTLE_MS   = 1000,
    parameter int unsigned TACH_TO_MS  = 250,
    parameter int unsigned T_ON        = DEF_T_ON,
    parameter int unsigned T_HYST      = DEF_T_HYST,
    parameter int unsigned RPM_MIN     = DEF_RPM_MIN,
    parameter int unsigned RPM_PER_DEG = DEF_RPM_PER_DEG,
    parameter int unsigned RPM_MAX     = DEF_RPM_MAX,
    parameter int unsigned STALL_RPM   = 200,
    parameter int unsigned DUTY_MIN    = 51,
    parameter int unsigned DUTY_STEP   = 4,
    parameter int unsigned DEADBAND    = 50,
    parameter int unsigned MAX_RETRY   = 3,
    parameter int unsigned PWM_DIV     = 8
) (
    input logic           sys_clk,
    input logic           sys_rst_n,
    fan_speed_ctrl_if.slave bus
);

    localparam int unsigned TickW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

    logic [TickW-1:0] tick_q;
    logic             tick;
    logic [7:0]       temp_q;
    rpm_t             target_q, target_d;
    logic [2:0]       fg_sync_q;
    logic [15:0]      tach_q, tach_d;
    rpm_t             rpm_eff;
    fan_state_e       state_q, state_d;
    logic [15:0]      timer_q, timer_d;
    logic [7:0]       retry_q, retry_d;
    duty_t            duty_q, duty_d;
    duty_t            settle_duty, step_up, step_down;
    rpm_t             tgt_div;
    logic             temp_on, temp_off, rpm_low, rpm_high;

    // Free-running 1 ms tick.
    assign tick = (tick_q == TickW'(TICK_CYC - 1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick ? '0 : tick_q + TickW'(1);
        end
    end

    // Target follows the latched temperature one cycle later.
    assign target_d = temp_to_rpm(temp_q, T_ON, RPM_MIN, RPM_PER_DEG, RPM_MAX);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            temp_q   <= '0;
            target_q <= '0;
        end else begin
            if (bus.temp_valid) begin
                temp_q <= bus.temp_c;
            end
            target_q <= target_d;
        end
    end

    // The rpm input goes stale when the fan stops, so a missing fg edge overrides it.
    always_comb begin
        tach_d = tach_q;
        if (fg_sync_q[1] && !fg_sync_q[2]) begin
            tach_d = '0;
        end else if (tick && tach_q < 16'(TACH_TO_MS)) begin
            tach_d = tach_q + 16'd1;
        end
        rpm_eff = (tach_q >= 16'(TACH_TO_MS)) ? '0 : bus.rpm;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            fg_sync_q <= '0;
            tach_q    <= '0;
        end else begin
            fg_sync_q <= {fg_sync_q[1:0], bus.fg_signal};
            tach_q    <= tach_d;
        end
    end

    always_comb begin
        temp_on     = (temp_q >= 8'(T_ON));
        temp_off    = (temp_q < 8'(T_ON - T_HYST));
        tgt_div     = target_q >> 4;
        settle_duty = (tgt_div > rpm_t'(255)) ? 8'hFF : tgt_div[7:0];
        if (settle_duty < duty_t'(DUTY_MIN)) begin
            settle_duty = duty_t'(DUTY_MIN);
        end
        step_up   = (duty_q > duty_t'(255 - DUTY_STEP)) ? 8'hFF : duty_q + duty_t'(DUTY_STEP);
        step_down = (duty_q < duty_t'(DUTY_MIN + DUTY_STEP)) ? duty_t'(DUTY_MIN)
                                                              : duty_q - duty_t'(DUTY_STEP);
        // Compare with the deadband on the rpm side so a zero target cannot underflow.
        rpm_low   = (rpm_ext_t'(rpm_eff) + rpm_ext_t'(DEADBAND)) < rpm_ext_t'(target_q);
        rpm_high  = rpm_ext_t'(rpm_eff) > (rpm_ext_t'(target_q) + rpm_ext_t'(DEADBAND));
    end

    always_comb begin
        state_d = state_q;
        timer_d = tick ? timer_q + 16'd1 : timer_q;
        retry_d = retry_q;
        duty_d  = duty_q;

        case (state_q)
            StOff: begin
                if (temp_on) begin
                    state_d = StKick;
                    retry_d = '0;
                end
            end
            StKick: begin
                if (tick && timer_q == 16'(KICK_MS - 1)) begin
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (tick && timer_q == 16'(SETTLE_MS - 1)) begin
                    state_d = StRegulate;
                end
            end
            StRegulate: begin
                if (tick && timer_q == 16'(UPDATE_MS - 1)) begin
                    timer_d = '0;
                    if (rpm_eff < rpm_t'(STALL_RPM)) begin
                        state_d = StStall;
                    end else begin
                        retry_d = '0;
                        if (rpm_low) begin
                            duty_d = step_up;
                        end else if (rpm_high) begin
                            duty_d = step_down;
                        end
                    end
                end
            end
            StStall: begin
                if (tick) begin
                    if (retry_q < 8'(MAX_RETRY)) begin
                        retry_d = retry_q + 8'd1;
                        state_d = StKick;
                    end else begin
                        state_d = StFault;
                    end
                end
            end
            StFault: begin
                if (bus.fault_clr) begin
                    state_d = StOff;
                    retry_d = '0;
                end
            end
            default: state_d = StOff;
        endcase

        // Cooling down wins over every other transition; a latched fault stays latched.
        if (temp_off && (state_q inside {StKick, StSettle, StRegulate, StStall})) begin
            state_d = StOff;
        end

        if (state_d != state_q) begin
            timer_d = '0;
        end

        // Duty tracks the destination state so it changes on the same edge as the state.
        case (state_d)
            StOff, StStall, StFault: duty_d = '0;
            StKick:                  duty_d = 8'hFF;
            StSettle:                duty_d = settle_duty;
            default:                 ;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= StOff;
            timer_q <= '0;
            retry_q <= '0;
            duty_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
            duty_q  <= duty_d;
        end
    end

    fan_pwm_gen #(
        .PWM_DIV (PWM_DIV)
    ) u_pwm (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .duty      (duty_q),
        .pwm_out   (bus.pwm_out)
    );

    assign bus.duty        = duty_q;
    assign bus.target_rpm  = target_q;
    assign bus.state       = state_q;
    assign bus.stall_alarm = (state_q == StFault);

endmodule
